// File: rtl/ioctl_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ioctl_rom_loader
//  Description : Buffers the hps_io ioctl byte stream into a small FIFO,
//                filters it by index and address range, and commits it to
//                the Poly-Play ROM/RAM through a stallable write handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module ioctl_rom_loader #(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter int         ADDR_W    = 15,
    parameter int         ROM_SIZE  = 32768,
    parameter int         DEPTH     = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_we,
    input  logic              rom_ack,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [15:0]       checksum,
    output logic              range_err,
    output logic              ovf_err
);

    localparam int                 C_PTR_W     = $clog2(DEPTH);
    localparam int                 C_CNT_W     = C_PTR_W + 1;
    localparam int                 C_ENTRY_W   = ADDR_W + 8;
    localparam logic [C_CNT_W-1:0] C_DEPTH     = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_WAIT_LVL  = C_CNT_W'(DEPTH - 1);
    localparam logic [31:0]        C_ROM_LIMIT = 32'(ROM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [15:0]          checksum_q, checksum_d;
    logic                 range_err_q, range_err_d;
    logic                 ovf_err_q, ovf_err_d;
    logic                 ioctl_wait_q, ioctl_wait_d;
    logic [C_ENTRY_W-1:0] mem_q [DEPTH];

    logic                 w_index_ok;
    logic                 w_in_range;
    logic                 w_candidate;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start;
    logic [C_ENTRY_W-1:0] w_head;

    assign w_index_ok  = (ioctl_index == ROM_INDEX);
    assign w_in_range  = ({7'd0, ioctl_addr} < C_ROM_LIMIT);
    assign w_candidate = ioctl_wr && (state_q == ST_LOAD) && w_index_ok;
    assign w_full      = (count_q == C_DEPTH);
    assign w_empty     = (count_q == '0);
    // A full FIFO drops the byte even if the head is acknowledged this cycle.
    assign w_push      = w_candidate && w_in_range && !w_full;
    assign w_pop       = rom_ack && !w_empty;
    assign w_start     = (state_q == ST_IDLE) && ioctl_download && w_index_ok;
    assign w_head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_start)        state_d = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_d = ST_DRAIN;
            ST_DRAIN: if (w_empty)        state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        checksum_d  = checksum_q;
        range_err_d = range_err_q | (w_candidate && !w_in_range);
        ovf_err_d   = ovf_err_q | (w_candidate && w_in_range && w_full);

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            checksum_d = checksum_q + {8'd0, w_head[7:0]};
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (w_start) begin
            checksum_d  = '0;
            range_err_d = 1'b0;
            ovf_err_d   = 1'b0;
        end

        // Looking at the next count leaves room for the one write the HPS may
        // already have in flight when it first sees wait.
        ioctl_wait_d = (count_d >= C_WAIT_LVL);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            checksum_q   <= '0;
            range_err_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
            ioctl_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            checksum_q   <= checksum_d;
            range_err_q  <= range_err_d;
            ovf_err_q    <= ovf_err_d;
            ioctl_wait_q <= ioctl_wait_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_data};
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign rom_we     = !w_empty;
    assign rom_addr   = w_head[C_ENTRY_W-1:8];
    assign rom_data   = w_head[7:0];
    assign cpu_hold   = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_DONE);
    assign checksum   = checksum_q;
    assign range_err  = range_err_q;
    assign ovf_err    = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_rom_loader
//  Description : Scoreboard bench for ioctl_rom_loader with directed loads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ioctl_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we;
    logic        rom_ack;
    logic        cpu_hold;
    logic        load_done;
    logic [15:0] checksum;
    logic        range_err;
    logic        ovf_err;

    always #5 clk_sys = ~clk_sys;

    ioctl_rom_loader #(
        .ROM_INDEX (8'd0),
        .ADDR_W    (15),
        .ROM_SIZE  (32768),
        .DEPTH     (4)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .rom_ack        (rom_ack),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .checksum       (checksum),
        .range_err      (range_err),
        .ovf_err        (ovf_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic [22:0] exp_q[$];
    logic [22:0] mon_e;
    logic        hps_wait_q = 1'b0;

    // The HPS reacts to wait one cycle late, like a registered master.
    always @(posedge clk_sys) hps_wait_q <= ioctl_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && load_done) done_cnt++;
        if (reset_n && rom_we && rom_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {9'd0, rom_addr, rom_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_order", {9'd0, rom_addr, rom_data}, {9'd0, mon_e});
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic hps_write(input logic [24:0] a, input logic [7:0] d, input bit exp_ok);
        int guard = 0;
        while (hps_wait_q && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("hps_wait_timeout", 32'(ioctl_wait), 32'd0);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (exp_ok) exp_q.push_back({a[14:0], d});
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int exp_done);
        int guard = 0;
        while (!load_done && guard < 60) begin
            tick();
            guard++;
        end
        check("load_done_seen", 32'(load_done), 32'd1);
        tick();
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("cpu_hold_released", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        rom_ack        = 1'b0;
        repeat (3) tick();
        check("reset_flags", 32'({ioctl_wait, rom_we, cpu_hold, load_done, range_err, ovf_err}), 32'd0);
        check("reset_checksum", 32'(checksum), 32'd0);
        reset_n = 1'b1;
        tick();

        // T1: 16 bytes with ack tied high
        rom_ack = 1'b1;
        start_load(8'd0);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 16; i++) begin
            hps_write(25'(i), 8'(i), 1'b1);
            if (i == 0) check("t1_latency", 32'({rom_we, rom_addr}), 32'h0000_8000);
        end
        ioctl_download = 1'b0;
        wait_done(1);
        check("t1_checksum", 32'(checksum), 32'h0078);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // T2: memory stalled for 20 cycles, HPS honours wait
        rom_ack = 1'b0;
        start_load(8'd0);
        fork
            begin
                for (int i = 0; i < 6; i++) hps_write(25'(32'h100 + i), 8'(32'hA0 + i), 1'b1);
            end
            begin
                repeat (20) tick();
                check("t2_wait_high", 32'(ioctl_wait), 32'd1);
                check("t2_count_full", 32'(dut.count_q), 32'd4);
                check("t2_no_ovf", 32'(ovf_err), 32'd0);
                check("t2_head_stable", 32'({rom_we, rom_addr, rom_data}), 32'h0081_00A0);
                rom_ack = 1'b1;
            end
        join
        ioctl_download = 1'b0;
        wait_done(2);
        check("t2_ovf_final", 32'(ovf_err), 32'd0);
        check("t2_checksum", 32'(checksum), 32'h03CF);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // T3: wrong index is ignored entirely
        rom_ack = 1'b1;
        start_load(8'd1);
        check("t3_no_hold", 32'(cpu_hold), 32'd0);
        for (int i = 0; i < 4; i++) hps_write(25'(i), 8'(32'h50 + i), 1'b0);
        check("t3_no_we", 32'({rom_we, cpu_hold}), 32'd0);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        repeat (5) tick();
        check("t3_no_done", 32'(done_cnt), 32'd2);

        // T4: out-of-range byte dropped, last in-range address kept
        start_load(8'd0);
        hps_write(25'h10,   8'h11, 1'b1);
        hps_write(25'h8000, 8'h55, 1'b0);
        hps_write(25'h11,   8'h22, 1'b1);
        hps_write(25'h7FFF, 8'h01, 1'b1);
        ioctl_download = 1'b0;
        wait_done(3);
        check("t4_range_err", 32'(range_err), 32'd1);
        check("t4_checksum", 32'(checksum), 32'h0034);
        check("t4_no_ovf", 32'(ovf_err), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // T5: push and pop in the same cycle at count 2
        rom_ack = 1'b0;
        start_load(8'd0);
        check("t5_flags_cleared", 32'({range_err, checksum}), 32'd0);
        hps_write(25'h20, 8'h01, 1'b1);
        hps_write(25'h21, 8'h02, 1'b1);
        check("t5_count_before", 32'(dut.count_q), 32'd2);
        ioctl_addr = 25'h22;
        ioctl_data = 8'h03;
        ioctl_wr   = 1'b1;
        rom_ack    = 1'b1;
        exp_q.push_back({15'h22, 8'h03});
        tick();
        ioctl_wr = 1'b0;
        rom_ack  = 1'b0;
        check("t5_count_after", 32'(dut.count_q), 32'd2);
        check("t5_new_head", 32'({rom_addr, rom_data}), 32'h0000_2102);
        rom_ack        = 1'b1;
        ioctl_download = 1'b0;
        wait_done(4);
        check("t5_checksum", 32'(checksum), 32'h0006);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // T6: reset with 3 entries queued, then re-entry while download stays high
        rom_ack = 1'b0;
        start_load(8'd0);
        for (int i = 0; i < 3; i++) hps_write(25'(32'h30 + i), 8'(32'h61 + i), 1'b1);
        check("t6_count_3", 32'(dut.count_q), 32'd3);
        check("t6_wait_3", 32'(ioctl_wait), 32'd1);
        reset_n = 1'b0;
        tick();
        exp_q.delete();
        check("t6_reset_outputs", 32'({rom_we, cpu_hold, ioctl_wait}), 32'd0);
        check("t6_fifo_empty", 32'(dut.count_q), 32'd0);
        check("t6_checksum", 32'(checksum), 32'd0);
        reset_n = 1'b1;
        tick();
        check("t6_reentry_hold", 32'(cpu_hold), 32'd1);
        rom_ack = 1'b1;
        hps_write(25'h40, 8'h99, 1'b1);
        ioctl_download = 1'b0;
        wait_done(5);
        check("t6_reentry_checksum", 32'(checksum), 32'h0099);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
